// File: rtl/median_window_sched.sv
// Frame sequencer for the 3x3 median core: walks every valid window of a
// WIDTH x HEIGHT frame in row-major order. Pixels come from a 1-cycle-latency
// read RAM. Window columns are reused along a row. Each median goes out as one
// output RAM write.
module median_window_sched #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int ADDR_W  = 17,
    parameter int OADDR_W = 17
) (
    input  logic               clk_i_sched,
    input  logic               rst_i_sched,
    input  logic               start_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               rd_en_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    input  logic [7:0]         rd_data_i,
    output logic               med_en_o,
    output logic [71:0]        win_o,
    input  logic               med_done_i,
    input  logic [7:0]         med_data_i,
    output logic               wr_en_o,
    output logic [OADDR_W-1:0] wr_addr_o,
    output logic [7:0]         wr_data_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_DONE, S_WRITE, S_ADVANCE, S_DONE
    } state_t;

    localparam int CW = (WIDTH  > 3) ? $clog2(WIDTH)  : 2;
    localparam int RW = (HEIGHT > 3) ? $clog2(HEIGHT) : 2;
    localparam logic [CW-1:0]     C_LAST = CW'(WIDTH - 3);
    localparam logic [RW-1:0]     R_LAST = RW'(HEIGHT - 3);
    localparam logic [ADDR_W-1:0] ROW1   = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] ROW2   = ADDR_W'(2 * WIDTH);

    state_t               state_q, state_d;
    logic [RW-1:0]        r_q, r_d;
    logic [CW-1:0]        c_q, c_d;
    logic [ADDR_W-1:0]    row_base_q, row_base_d;   // r * WIDTH, kept incrementally
    logic                 nine_q, nine_d;           // 1: full 9-read fetch, 0: 3-read column
    logic [3:0]           rd_cnt_q, rd_cnt_d;
    logic                 cap_vld_q, cap_vld_d;
    logic [3:0]           cap_slot_q, cap_slot_d;
    logic [8:0][7:0]      win_q, win_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [OADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [7:0]           med_q, med_d;
    logic [OADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;

    logic [1:0]           row_off, col_off;
    logic [3:0]           rd_slot, n_reads;
    logic [ADDR_W-1:0]    row_ofs_addr, rd_addr_calc;
    logic                 rd_en, wr_en;

    // Address/slot of the current read: column-major 9-read, or the new right column
    always_comb begin
        row_off = 2'd0;
        col_off = 2'd2;
        if (nine_q) begin
            case (rd_cnt_q)
                4'd0:    begin row_off = 2'd0; col_off = 2'd0; end
                4'd1:    begin row_off = 2'd1; col_off = 2'd0; end
                4'd2:    begin row_off = 2'd2; col_off = 2'd0; end
                4'd3:    begin row_off = 2'd0; col_off = 2'd1; end
                4'd4:    begin row_off = 2'd1; col_off = 2'd1; end
                4'd5:    begin row_off = 2'd2; col_off = 2'd1; end
                4'd6:    begin row_off = 2'd0; col_off = 2'd2; end
                4'd7:    begin row_off = 2'd1; col_off = 2'd2; end
                default: begin row_off = 2'd2; col_off = 2'd2; end
            endcase
        end else begin
            row_off = rd_cnt_q[1:0];
            col_off = 2'd2;
        end
        case (row_off)
            2'd0:    row_ofs_addr = '0;
            2'd1:    row_ofs_addr = ROW1;
            default: row_ofs_addr = ROW2;
        endcase
        rd_slot      = {2'b00, row_off} * 4'd3 + {2'b00, col_off};
        rd_addr_calc = row_base_q + row_ofs_addr + ADDR_W'(c_q) + ADDR_W'(col_off);
        n_reads      = nine_q ? 4'd9 : 4'd3;
    end

    assign rd_en        = (state_q == S_FETCH) && (rd_cnt_q < n_reads);
    assign wr_en        = (state_q == S_WRITE);
    assign rd_en_o      = rd_en;
    assign rd_addr_o    = rd_en ? rd_addr_calc : rd_addr_q;
    assign wr_en_o      = wr_en;
    assign wr_addr_o    = wr_en ? wr_cnt_q : wr_addr_q;
    assign wr_data_o    = wr_en ? med_q : wr_data_q;
    assign med_en_o     = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
    assign win_o        = win_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = (state_q == S_DONE);

    // Next-state, counters, window capture/shift and held output values
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        row_base_d = row_base_q;
        nine_d     = nine_q;
        rd_cnt_d   = rd_cnt_q + {3'b000, rd_en};
        cap_vld_d  = rd_en;
        cap_slot_d = rd_en ? rd_slot : cap_slot_q;
        win_d      = win_q;
        rd_addr_d  = rd_addr_o;
        wr_cnt_d   = wr_cnt_q;
        med_d      = med_q;
        wr_addr_d  = wr_addr_o;
        wr_data_d  = wr_data_o;

        // read data lands one cycle after its strobe
        if (cap_vld_q) win_d[cap_slot_q] = rd_data_i;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    r_d        = '0;
                    c_d        = '0;
                    row_base_d = '0;
                    nine_d     = 1'b1;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // all reads issued; the last byte is captured this cycle
                if (rd_cnt_q == n_reads) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (med_done_i) begin
                    med_d   = med_data_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_cnt_d = wr_cnt_q + OADDR_W'(1);
                state_d  = S_ADVANCE;
            end
            S_ADVANCE: begin
                rd_cnt_d = '0;
                if (c_q < C_LAST) begin
                    c_d    = c_q + CW'(1);
                    nine_d = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        win_d[3*k]   = win_q[3*k+1];
                        win_d[3*k+1] = win_q[3*k+2];
                    end
                    state_d = S_FETCH;
                end else if (r_q < R_LAST) begin
                    r_d        = r_q + RW'(1);
                    c_d        = '0;
                    row_base_d = row_base_q + ROW1;
                    nine_d     = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i_sched) begin
        if (!rst_i_sched) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            row_base_q <= '0;
            nine_q     <= 1'b0;
            rd_cnt_q   <= '0;
            cap_vld_q  <= 1'b0;
            cap_slot_q <= '0;
            win_q      <= '0;
            rd_addr_q  <= '0;
            wr_cnt_q   <= '0;
            med_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            row_base_q <= row_base_d;
            nine_q     <= nine_d;
            rd_cnt_q   <= rd_cnt_d;
            cap_vld_q  <= cap_vld_d;
            cap_slot_q <= cap_slot_d;
            win_q      <= win_d;
            rd_addr_q  <= rd_addr_d;
            wr_cnt_q   <= wr_cnt_d;
            med_q      <= med_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule
